fd_multicycle: RTL

//   Multicycle RISC-V datapath (FD), the counterpart of control unit uc: executes the strobes uc issues per state
//   (FETCH/DECODE/EXECUTE/WRITE_BACK) and returns opcode/funct fields and ALU flags for its decisions.

---
 rtl/fd_multicycle.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fd_multicycle.sv
`default_nettype none
// ============================================================================
// Module : fd_multicycle
// Multicycle RISC-V datapath: PC, IR, register file, A/B/ALUOut/MDR and ALU.
// Option : FD_ALU_FLAGS_REG_EN registers alu_flags in step with ALUOut.
// Rev    : 1.0  initial release
// ============================================================================
module fd_multicycle #(
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ir_we,
  input  logic              pc_we,
  input  logic              pc_src,
  input  logic              alu_src,
  input  logic [3:0]        alu_cmd,
  input  logic              rf_we,
  input  logic              rf_src,
  input  logic              d_mem_we,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic              funct7,
  output logic [3:0]        alu_flags,
  output logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_rdata,
  output logic [ADDR_W-1:0] d_mem_addr,
  output logic [XLEN-1:0]   d_mem_wdata,
  output logic              d_mem_we_o,
  input  logic [XLEN-1:0]   d_mem_rdata
);

  localparam logic [31:0]     c_nop       = 32'h0000_0013;
  localparam logic [XLEN-1:0] c_reset_pc  = XLEN'(RESET_PC);
  localparam logic [3:0]      c_alu_add   = 4'b0010;
  localparam logic [3:0]      c_alu_sub   = 4'b0110;
  localparam logic [3:0]      c_alu_and   = 4'b0000;
  localparam logic [3:0]      c_alu_or    = 4'b0001;
  localparam logic [6:0]      c_op_load   = 7'b0000011;
  localparam logic [6:0]      c_op_imm    = 7'b0010011;
  localparam logic [6:0]      c_op_store  = 7'b0100011;
  localparam logic [6:0]      c_op_branch = 7'b1100011;

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_alu_out;
  logic [XLEN-1:0] r_mdr;
  logic [XLEN-1:0] r_rf [32];

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_sb;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_sub;
  logic [XLEN-1:0] w_result;
  logic            w_carry;
  logic            w_ovf;
  logic [3:0]      w_flags;
  logic [XLEN-1:0] w_wb_data;

  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_rd  = r_ir[11:7];

  assign w_imm_i  = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s  = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_sb = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

  always_comb begin
    w_imm = '0;
    case (r_ir[6:0])
      c_op_load, c_op_imm: w_imm = w_imm_i;
      c_op_store:          w_imm = w_imm_s;
      c_op_branch:         w_imm = w_imm_sb;
      default:             w_imm = '0;
    endcase
  end

  // Subtraction as A + ~B + 1 so the carry-out is directly "no borrow".
  assign w_op_b = alu_src ? w_imm : r_b;
  assign w_add  = {1'b0, r_a} + {1'b0, w_op_b};
  assign w_sub  = {1'b0, r_a} + {1'b0, ~w_op_b} + (XLEN+1)'(1);

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (alu_cmd)
      c_alu_add: begin
        {w_carry, w_result} = w_add;
        w_ovf = (r_a[XLEN-1] == w_op_b[XLEN-1]) && (w_result[XLEN-1] != r_a[XLEN-1]);
      end
      c_alu_sub: begin
        {w_carry, w_result} = w_sub;
        w_ovf = (r_a[XLEN-1] != w_op_b[XLEN-1]) && (w_result[XLEN-1] != r_a[XLEN-1]);
      end
      c_alu_and: w_result = r_a & w_op_b;
      c_alu_or:  w_result = r_a | w_op_b;
      default:   w_result = '0;
    endcase
  end

  assign w_flags   = {(w_result == '0), w_result[XLEN-1], w_carry, w_ovf};
  assign w_wb_data = rf_src ? r_mdr : r_alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= c_reset_pc;
      r_ir      <= c_nop;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      r_a       <= r_rf[w_rs1];
      r_b       <= r_rf[w_rs2];
      r_alu_out <= w_result;
      r_mdr     <= d_mem_rdata;
      if (ir_we) r_ir <= i_mem_rdata;
      if (pc_we) r_pc <= pc_src ? (r_pc + w_imm_sb) : (r_pc + XLEN'(4));
    end
  end

  // x0 is never written, so it reads zero without a read-side mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (rf_we && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= w_wb_data;
    end
  end

`ifdef FD_ALU_FLAGS_REG_EN
  logic [3:0] r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flags <= 4'b1000;
    else        r_flags <= w_flags;
  end

  assign alu_flags = r_flags;
`else
  assign alu_flags = w_flags;
`endif

  assign opcode      = r_ir[6:0];
  assign funct3      = r_ir[14:12];
  assign funct7      = r_ir[30];
  assign i_mem_addr  = r_pc[ADDR_W-1:0];
  assign d_mem_addr  = r_alu_out[ADDR_W-1:0];
  assign d_mem_wdata = r_b;
  assign d_mem_we_o  = d_mem_we;

  logic w_unused;
  assign w_unused = &{1'b0, r_pc[XLEN-1:ADDR_W], r_alu_out[XLEN-1:ADDR_W]};

endmodule
`default_nettype wire
